// File: rtl/eth_udp_pkt_gen_pkg.sv
// Shared constants for the IPv4/UDP packet generator: FSM encodings,
// header lengths and fixed IPv4 field values.
package eth_udp_pkt_gen_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CSUM    = 3'd1;
  localparam logic [2:0] ST_FOLD    = 3'd2;
  localparam logic [2:0] ST_HDR     = 3'd3;
  localparam logic [2:0] ST_PAYLOAD = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;

  localparam logic [15:0] IPV4_HDR_LEN  = 16'd20;
  localparam logic [15:0] UDP_HDR_LEN   = 16'd8;
  localparam logic [7:0]  IP_PROTO_UDP  = 8'h11;
  localparam logic [15:0] IP_FLAGS_WORD = 16'h4000;

  localparam logic [4:0] CSUM_LAST = 5'd9;
  localparam logic [4:0] HDR_LAST  = 5'd27;

endpackage

// File: rtl/eth_udp_pkt_gen_if.sv
// Command, payload-in and byte-out signals of eth_udp_pkt_gen.
// The generator uses the master modport; the user/transmit side uses slave.
interface eth_udp_pkt_gen_if;

  logic        Start;
  logic [10:0] Payload_Len;
  logic [7:0]  Usr_Byte;
  logic        Usr_Byte_Valid;
  logic        Usr_Byte_Rdy;
  logic [7:0]  Eth_Byte;
  logic        Eth_Byte_Valid;
  logic        Eth_Pkt_Rdy;
  logic        Busy;
  logic        Len_Err;

  modport master (
    input  Start, Payload_Len, Usr_Byte, Usr_Byte_Valid,
    output Usr_Byte_Rdy, Eth_Byte, Eth_Byte_Valid, Eth_Pkt_Rdy, Busy, Len_Err
  );

  modport slave (
    output Start, Payload_Len, Usr_Byte, Usr_Byte_Valid,
    input  Usr_Byte_Rdy, Eth_Byte, Eth_Byte_Valid, Eth_Pkt_Rdy, Busy, Len_Err
  );

endinterface

// File: rtl/eth_udp_pkt_gen_ipv4_csum.sv
// 16-bit ones-complement accumulator for the IPv4 header checksum:
// clear, add one word per cycle with end-around carry, then fold and invert.
module eth_udp_pkt_gen_ipv4_csum (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        clr,
  input  logic        add,
  input  logic        fold,
  input  logic [15:0] word,
  output logic [15:0] result
);

  logic [16:0] acc;

  // The carry from the previous add is folded back in with the next word,
  // so acc never exceeds 17'h1FFFE and the final fold cannot carry again.
  always_ff @(posedge Clk) begin
    if (Rst || clr) begin
      acc <= '0;
    end else if (add) begin
      acc <= {1'b0, acc[15:0]} + {16'd0, acc[16]} + {1'b0, word};
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      result <= '0;
    end else if (fold) begin
      result <= ~(acc[15:0] + {15'd0, acc[16]});
    end
  end

endmodule

// File: rtl/eth_udp_pkt_gen.sv
// Builds an IPv4+UDP datagram (headers plus user payload) as a byte stream.
// Optional macro ETH_IPV4_ID_INCR_EN: Identification counts up per packet.
module eth_udp_pkt_gen
  import eth_udp_pkt_gen_pkg::*;
#(
  parameter logic [31:0] pSRC_IP      = 32'hC0A80102,
  parameter logic [31:0] pDST_IP      = 32'hC0A80101,
  parameter logic [15:0] pSRC_PORT    = 16'd5000,
  parameter logic [15:0] pDST_PORT    = 16'd5001,
  parameter logic [7:0]  pTTL         = 8'h40,
  parameter logic [10:0] pMAX_PAYLOAD = 11'd1472
) (
  input logic            Clk,
  input logic            Rst,
  eth_udp_pkt_gen_if.master bus
);

  logic [2:0]  state;
  logic [4:0]  cnt;
  logic [10:0] len_q;
  logic [10:0] remaining;
  logic [15:0] ip_id;
  logic [15:0] csum;
  logic [15:0] csum_word;
  logic [15:0] tot_len;
  logic [15:0] udp_len;
  logic [4:0]  hdr_idx;
  logic [7:0]  hdr_byte;
  logic        start_ok;
  logic        usr_accept;
  logic        usr_rdy;
  logic        hdr_load;
  logic [7:0]  eth_byte;
  logic        eth_valid;
  logic        len_err;

  assign start_ok = (state == ST_IDLE) && bus.Start && (bus.Payload_Len <= pMAX_PAYLOAD);
  assign tot_len  = {5'd0, len_q} + IPV4_HDR_LEN + UDP_HDR_LEN;
  assign udp_len  = {5'd0, len_q} + UDP_HDR_LEN;

  // The first payload byte is taken in the last header cycle so the stream has no gap.
  assign usr_rdy    = (remaining != 11'd0) &&
                      ((state == ST_PAYLOAD) || ((state == ST_HDR) && (cnt == HDR_LAST)));
  assign usr_accept = usr_rdy && bus.Usr_Byte_Valid;

  // Eth_Byte is registered, so each header byte is loaded one cycle before it shows.
  assign hdr_load = (state == ST_FOLD) || ((state == ST_HDR) && (cnt != HDR_LAST));
  assign hdr_idx  = (state == ST_HDR) ? (cnt + 5'd1) : 5'd0;

`ifdef ETH_IPV4_ID_INCR_EN
  always_ff @(posedge Clk) begin
    if (Rst) begin
      ip_id <= 16'h0000;
    end else if (state == ST_DONE) begin
      ip_id <= ip_id + 16'd1;
    end
  end
`else
  assign ip_id = 16'h0000;
`endif

  always_comb begin
    csum_word = 16'h0000;
    case (cnt)
      5'd0:    csum_word = 16'h4500;
      5'd1:    csum_word = tot_len;
      5'd2:    csum_word = ip_id;
      5'd3:    csum_word = IP_FLAGS_WORD;
      5'd4:    csum_word = {pTTL, IP_PROTO_UDP};
      5'd6:    csum_word = pSRC_IP[31:16];
      5'd7:    csum_word = pSRC_IP[15:0];
      5'd8:    csum_word = pDST_IP[31:16];
      5'd9:    csum_word = pDST_IP[15:0];
      default: csum_word = 16'h0000;
    endcase
  end

  eth_udp_pkt_gen_ipv4_csum u_csum (
    .Clk    (Clk),
    .Rst    (Rst),
    .clr    (start_ok),
    .add    (state == ST_CSUM),
    .fold   (state == ST_FOLD),
    .word   (csum_word),
    .result (csum)
  );

  always_comb begin
    hdr_byte = 8'h00;
    case (hdr_idx)
      5'd0:    hdr_byte = 8'h45;
      5'd2:    hdr_byte = tot_len[15:8];
      5'd3:    hdr_byte = tot_len[7:0];
      5'd4:    hdr_byte = ip_id[15:8];
      5'd5:    hdr_byte = ip_id[7:0];
      5'd6:    hdr_byte = IP_FLAGS_WORD[15:8];
      5'd7:    hdr_byte = IP_FLAGS_WORD[7:0];
      5'd8:    hdr_byte = pTTL;
      5'd9:    hdr_byte = IP_PROTO_UDP;
      5'd10:   hdr_byte = csum[15:8];
      5'd11:   hdr_byte = csum[7:0];
      5'd12:   hdr_byte = pSRC_IP[31:24];
      5'd13:   hdr_byte = pSRC_IP[23:16];
      5'd14:   hdr_byte = pSRC_IP[15:8];
      5'd15:   hdr_byte = pSRC_IP[7:0];
      5'd16:   hdr_byte = pDST_IP[31:24];
      5'd17:   hdr_byte = pDST_IP[23:16];
      5'd18:   hdr_byte = pDST_IP[15:8];
      5'd19:   hdr_byte = pDST_IP[7:0];
      5'd20:   hdr_byte = pSRC_PORT[15:8];
      5'd21:   hdr_byte = pSRC_PORT[7:0];
      5'd22:   hdr_byte = pDST_PORT[15:8];
      5'd23:   hdr_byte = pDST_PORT[7:0];
      5'd24:   hdr_byte = udp_len[15:8];
      5'd25:   hdr_byte = udp_len[7:0];
      default: hdr_byte = 8'h00;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      len_q     <= '0;
      remaining <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_ok) begin
            state     <= ST_CSUM;
            cnt       <= '0;
            len_q     <= bus.Payload_Len;
            remaining <= bus.Payload_Len;
          end
        end
        ST_CSUM: begin
          if (cnt == CSUM_LAST) begin
            state <= ST_FOLD;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
        ST_FOLD: state <= ST_HDR;
        ST_HDR: begin
          if (cnt == HDR_LAST) begin
            state <= (len_q == 11'd0) ? ST_DONE : ST_PAYLOAD;
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
        ST_PAYLOAD: begin
          if (remaining == 11'd0) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
      if (usr_accept) begin
        remaining <= remaining - 11'd1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      eth_byte  <= '0;
      eth_valid <= 1'b0;
      len_err   <= 1'b0;
    end else begin
      len_err   <= (state == ST_IDLE) && bus.Start && (bus.Payload_Len > pMAX_PAYLOAD);
      eth_valid <= hdr_load || usr_accept;
      if (hdr_load) begin
        eth_byte <= hdr_byte;
      end else if (usr_accept) begin
        eth_byte <= bus.Usr_Byte;
      end
    end
  end

  assign bus.Usr_Byte_Rdy   = usr_rdy;
  assign bus.Eth_Byte       = eth_byte;
  assign bus.Eth_Byte_Valid = eth_valid;
  assign bus.Eth_Pkt_Rdy    = (state == ST_DONE);
  assign bus.Busy           = (state != ST_IDLE);
  assign bus.Len_Err        = len_err;

endmodule

// File: tb/tb_eth_udp_pkt_gen.sv
// Directed bench for eth_udp_pkt_gen: header bytes, payload, timing,
// length error, ignored Start, mid-packet reset and optional ID increment.
module tb_eth_udp_pkt_gen;

  logic Clk = 1'b0;
  logic Rst;
  int   checks = 0;
  int   errors = 0;

  logic [7:0] exp_hdr [0:27];
  logic [7:0] got [$];

  eth_udp_pkt_gen_if bus ();

  eth_udp_pkt_gen dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  always #5 Clk = ~Clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic start, input logic [10:0] len);
    bus.Start       = start;
    bus.Payload_Len = len;
  endtask

  // Starts a packet now (edge + 1) and follows it cycle by cycle; cycle n is
  // the n-th cycle after the edge that accepted Start.
  task automatic runPacket(input string tag, input int len, input bit toggle,
                           input int exp_rdy_cyc, input int exp_last_valid, input int exp_rdy_high);
    int n;
    int first_v;
    int last_v;
    int rdy_cyc;
    int rdy_cnt;
    int rdy_high;
    int usr_idx;
    int busy_at_rdy;
    bit acc;
    got.delete();
    first_v = -1; last_v = -1; rdy_cyc = -1; rdy_cnt = 0;
    rdy_high = 0; usr_idx = 0; busy_at_rdy = 0;
    applyStimulus(1'b1, len[10:0]);
    @(posedge Clk); #1;
    applyStimulus(1'b0, 11'd0);
    checkOutput({tag, " busy_after_start"}, {31'd0, bus.Busy}, 32'd1);
    for (n = 1; n <= 120 && rdy_cyc < 0; n++) begin
      if (bus.Eth_Byte_Valid) begin
        got.push_back(bus.Eth_Byte);
        if (first_v < 0) first_v = n;
        last_v = n;
      end
      if (bus.Eth_Pkt_Rdy) begin
        rdy_cnt++;
        rdy_cyc     = n;
        busy_at_rdy = int'(bus.Busy);
      end
      bus.Usr_Byte_Valid = toggle ? n[0] : 1'b1;
      bus.Usr_Byte       = usr_idx[7:0];
      acc = bus.Usr_Byte_Valid && bus.Usr_Byte_Rdy;
      if (bus.Usr_Byte_Rdy) rdy_high++;
      @(posedge Clk); #1;
      if (acc) usr_idx++;
    end
    bus.Usr_Byte_Valid = 1'b0;
    checkOutput({tag, " first_valid_cycle"}, first_v, 32'd12);
    checkOutput({tag, " last_valid_cycle"}, last_v, exp_last_valid);
    checkOutput({tag, " pkt_rdy_cycle"}, rdy_cyc, exp_rdy_cyc);
    checkOutput({tag, " pkt_rdy_count"}, rdy_cnt, 32'd1);
    checkOutput({tag, " busy_at_pkt_rdy"}, busy_at_rdy, 32'd1);
    checkOutput({tag, " busy_after_pkt"}, {31'd0, bus.Busy}, 32'd0);
    checkOutput({tag, " byte_count"}, got.size(), 28 + len);
    checkOutput({tag, " usr_rdy_cycles"}, rdy_high, exp_rdy_high);
    for (int i = 0; i < 28; i++)
      checkOutput($sformatf("%s hdr%0d", tag, i), {24'd0, got[i]}, {24'd0, exp_hdr[i]});
    for (int i = 0; i < len; i++)
      checkOutput($sformatf("%s pay%0d", tag, i), {24'd0, got[28 + i]}, i);
  endtask

  initial begin
    $display("[TB] start");
    Rst = 1'b1;
    applyStimulus(1'b0, 11'd0);
    bus.Usr_Byte       = 8'h00;
    bus.Usr_Byte_Valid = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    checkOutput("reset eth_valid", {31'd0, bus.Eth_Byte_Valid}, 32'd0);
    checkOutput("reset eth_byte", {24'd0, bus.Eth_Byte}, 32'd0);
    checkOutput("reset pkt_rdy", {31'd0, bus.Eth_Pkt_Rdy}, 32'd0);
    checkOutput("reset busy", {31'd0, bus.Busy}, 32'd0);
    checkOutput("reset len_err", {31'd0, bus.Len_Err}, 32'd0);
    checkOutput("reset usr_rdy", {31'd0, bus.Usr_Byte_Rdy}, 32'd0);
    Rst = 1'b0;
    @(posedge Clk); #1;

    exp_hdr = '{8'h45, 8'h00, 8'h00, 8'h2E, 8'h00, 8'h00, 8'h40, 8'h00, 8'h40, 8'h11,
                8'hB7, 8'h6B, 8'hC0, 8'hA8, 8'h01, 8'h02, 8'hC0, 8'hA8, 8'h01, 8'h01,
                8'h13, 8'h88, 8'h13, 8'h89, 8'h00, 8'h1A, 8'h00, 8'h00};
    runPacket("len18", 18, 1'b0, 58, 57, 18);

`ifdef ETH_IPV4_ID_INCR_EN
    exp_hdr[5]  = 8'h01;
    exp_hdr[11] = 8'h6A;
`endif
    runPacket("len18_bubbles", 18, 1'b1, 75, 74, 35);

    exp_hdr = '{8'h45, 8'h00, 8'h00, 8'h1C, 8'h00, 8'h00, 8'h40, 8'h00, 8'h40, 8'h11,
                8'hB7, 8'h7D, 8'hC0, 8'hA8, 8'h01, 8'h02, 8'hC0, 8'hA8, 8'h01, 8'h01,
                8'h13, 8'h88, 8'h13, 8'h89, 8'h00, 8'h08, 8'h00, 8'h00};
`ifdef ETH_IPV4_ID_INCR_EN
    exp_hdr[5]  = 8'h02;
    exp_hdr[11] = 8'h7B;
`endif
    runPacket("len0", 0, 1'b0, 40, 39, 0);

    applyStimulus(1'b1, 11'd1473);
    @(posedge Clk); #1;
    applyStimulus(1'b0, 11'd0);
    checkOutput("len1473 len_err", {31'd0, bus.Len_Err}, 32'd1);
    checkOutput("len1473 busy", {31'd0, bus.Busy}, 32'd0);
    @(posedge Clk); #1;
    checkOutput("len1473 len_err_pulse_end", {31'd0, bus.Len_Err}, 32'd0);
    checkOutput("len1473 busy_after", {31'd0, bus.Busy}, 32'd0);
    checkOutput("len1473 no_bytes", {31'd0, bus.Eth_Byte_Valid}, 32'd0);

    applyStimulus(1'b1, 11'd1472);
    @(posedge Clk); #1;
    applyStimulus(1'b0, 11'd0);
    checkOutput("len1472 len_err", {31'd0, bus.Len_Err}, 32'd0);
    checkOutput("len1472 busy", {31'd0, bus.Busy}, 32'd1);
    repeat (12) @(posedge Clk);
    #1;
    applyStimulus(1'b1, 11'd5);
    @(posedge Clk); #1;
    applyStimulus(1'b0, 11'd0);
    checkOutput("ignored_start totlen_hi", {24'd0, bus.Eth_Byte}, 32'h05);
    checkOutput("ignored_start len_err", {31'd0, bus.Len_Err}, 32'd0);
    @(posedge Clk); #1;
    checkOutput("ignored_start totlen_lo", {24'd0, bus.Eth_Byte}, 32'hDC);
    repeat (2) @(posedge Clk);
    #1;
    checkOutput("rst_mid byte5_valid", {31'd0, bus.Eth_Byte_Valid}, 32'd1);
    Rst = 1'b1;
    @(posedge Clk); #1;
    checkOutput("rst_mid eth_valid", {31'd0, bus.Eth_Byte_Valid}, 32'd0);
    checkOutput("rst_mid eth_byte", {24'd0, bus.Eth_Byte}, 32'd0);
    checkOutput("rst_mid busy", {31'd0, bus.Busy}, 32'd0);
    checkOutput("rst_mid pkt_rdy", {31'd0, bus.Eth_Pkt_Rdy}, 32'd0);
    Rst = 1'b0;
    @(posedge Clk); #1;

    exp_hdr = '{8'h45, 8'h00, 8'h00, 8'h2E, 8'h00, 8'h00, 8'h40, 8'h00, 8'h40, 8'h11,
                8'hB7, 8'h6B, 8'hC0, 8'hA8, 8'h01, 8'h02, 8'hC0, 8'hA8, 8'h01, 8'h01,
                8'h13, 8'h88, 8'h13, 8'h89, 8'h00, 8'h1A, 8'h00, 8'h00};
    runPacket("after_rst len18", 18, 1'b0, 58, 57, 18);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/eth_udp_pkt_gen.md
Name: eth_udp_pkt_gen

Overview:
- Upstream packet source for the RMII transmit stage.
- On a Start pulse it emits a complete IPv4+UDP datagram as a byte stream on Eth_Byte/Eth_Byte_Valid: a 20-byte IPv4 header with computed header checksum, an 8-byte UDP header, then the user payload.
- It pulses Eth_Pkt_Rdy after the last byte, which tells the transmit stage to start framing. The Ethernet MAC header, padding and FCS are added downstream, not here.

Parameters:
- pSRC_IP, 32'hC0A80102, IPv4 source address.
- pDST_IP, 32'hC0A80101, IPv4 destination address.
- pSRC_PORT, 16'd5000, UDP source port.
- pDST_PORT, 16'd5001, UDP destination port.
- pTTL, 8'h40, IPv4 time-to-live.
- pMAX_PAYLOAD, 11'd1472, largest accepted payload length in bytes. Must not exceed the transmit FIFO depth minus 28.

Ports:
- Clk  in  1  clock
- Rst  in  1  reset, synchronous, active-high
- Start  in  1  one-cycle request to build a packet; accepted only in IDLE
- Payload_Len  in  11  payload byte count, sampled when Start is accepted
- Usr_Byte  in  8  payload byte
- Usr_Byte_Valid  in  1  Usr_Byte is valid
- Usr_Byte_Rdy  out  1  generator accepts a payload byte this cycle
- Eth_Byte  out  8  output byte, network order, registered
- Eth_Byte_Valid  out  1  Eth_Byte is valid; one byte per high cycle
- Eth_Pkt_Rdy  out  1  one-cycle pulse: the complete packet has been written
- Busy  out  1  high from the cycle after Start is accepted through the Eth_Pkt_Rdy cycle
- Len_Err  out  1  one-cycle pulse: Start was rejected because Payload_Len > pMAX_PAYLOAD

Behaviour:
- Reset: all outputs 0. FSM goes to IDLE. Checksum accumulator, byte counter and ID register are cleared.
- FSM states: IDLE -> CSUM -> FOLD -> HDR -> PAYLOAD -> DONE -> IDLE.
- IDLE:
  - Start with Payload_Len <= pMAX_PAYLOAD: latch the length and go to CSUM.
  - Start with Payload_Len too large: pulse Len_Err next cycle and stay in IDLE.
  - Start in any other state is ignored.
- CSUM (10 cycles): add one 16-bit header word per cycle into a 17-bit accumulator, folding the carry in on every add. The checksum word itself is taken as 0.
- Word order: 4500, TotLen, ID, 4000, {pTTL,8'h11}, 0000, pSRC_IP[31:16], pSRC_IP[15:0], pDST_IP[31:16], pDST_IP[15:0].
- Length fields: TotLen = Payload_Len + 28; UDP length = Payload_Len + 8. Both are 16-bit, zero-extended.
- FOLD (1 cycle): fold the final carry, then Csum = ~sum[15:0].
- HDR (28 cycles): emit the 20 IPv4 bytes, then the UDP header: ports, length, checksum 0000. All fields MSB byte first. Eth_Byte_Valid is high every cycle.
- Header timing: Start accepted at cycle T gives the first header byte valid at T+12 and the last at T+39.
- PAYLOAD:
  - Usr_Byte_Rdy is high while payload bytes remain.
  - Each cycle with Usr_Byte_Valid and Usr_Byte_Rdy both high moves the byte to Eth_Byte on the next cycle with Eth_Byte_Valid high.
  - Cycles with Usr_Byte_Valid low insert bubbles (Eth_Byte_Valid low). No timeout.
  - Usr_Byte_Rdy drops in the same cycle the last byte is accepted.
- Payload_Len = 0: PAYLOAD is skipped and Usr_Byte_Rdy never asserts.
- DONE: Eth_Pkt_Rdy pulses in the cycle after the last valid byte, then the FSM returns to IDLE. Back-to-back Start is accepted the following cycle.
- Rst mid-packet: immediate return to IDLE, with no Eth_Pkt_Rdy and no further bytes. The downstream FIFO shares Rst, so partial bytes are discarded.

Optional Feature:
- Macro: ETH_IPV4_ID_INCR_EN.
- Defined: the IPv4 Identification field is a 16-bit counter, used as-is for the current packet and incremented at DONE. It wraps FFFF -> 0000 and is reset to 0.
- Undefined: Identification is constant 16'h0000 and no counter register exists.

Decomposition:
- Shared package eth_udp_pkg.vh holds:
  - state encodings;
  - header length constants (IPv4 = 20, UDP = 8);
  - protocol constant 8'h11;
  - flags word 16'h4000.
- One sub-module: ipv4_csum, the 16-bit ones-complement accumulate/fold unit with clear, add and fold controls and a 16-bit result.

Test Plan:
- Default parameters, Payload_Len = 18, Usr bytes 00..11 always valid:
  - header bytes 45 00 00 2E 00 00 40 00 40 11 B7 6B C0 A8 01 02 C0 A8 01 01 13 88 13 89 00 1A 00 00;
  - then bytes 00..11;
  - 46 valid cycles, Eth_Pkt_Rdy at T+58.
- Same packet with Usr_Byte_Valid toggling 1/0 -> identical byte sequence, bubbles on Eth_Byte_Valid, single Eth_Pkt_Rdy after byte 46.
- Payload_Len = 0 -> 28 bytes, TotLen 001C, UDP length 0008, Usr_Byte_Rdy never high, Eth_Pkt_Rdy at T+40.
- Payload_Len = 1473 -> Len_Err pulse, Busy stays 0, no bytes. Start pulses while Busy -> ignored.
- Rst asserted at header byte 5 -> all outputs 0 the next cycle. A following Start produces a complete correct packet.
- With ETH_IPV4_ID_INCR_EN, three packets -> ID 0000, 0001, 0002, and checksum recomputed for each: B76B, B76A, B769 for the 18-byte case.
